operand_sequencer: RTL

- Address-mode controller between instruction decode and the memory bus of the 6502 core.
- On a start pulse it takes the decoded addressing mode (addmod_t), PC, X and Y, and issues the operand and pointer reads the mode needs.
- It then returns the effective address (EA) and the PC advance count.
- It owns the memory read port for the whole operand phase; the fetch/decode sequencer resumes when done pulses.

---
 rtl/operand_sequencer_pkg.sv | 52 +++++
 rtl/operand_sequencer_ea_calc.sv | 31 +++
 rtl/operand_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/operand_sequencer_pkg.sv
// Shared types for the 6502 operand sequencer: bus widths, addressing modes,
// sequencer states and per-mode helper functions.
package operand_sequencer_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  // Encodings above AM_IMP are undefined and reported as errors.
  typedef enum logic [3:0] {
    AM_UADDMOD = 4'd0,
    AM_ACC     = 4'd1,
    AM_IMM     = 4'd2,
    AM_REL     = 4'd3,
    AM_ZP      = 4'd4,
    AM_ZPX     = 4'd5,
    AM_ZPY     = 4'd6,
    AM_ABS     = 4'd7,
    AM_ABSX    = 4'd8,
    AM_ABSY    = 4'd9,
    AM_IXID    = 4'd10,
    AM_IDIX    = 4'd11,
    AM_INDY    = 4'd12,
    AM_IMP     = 4'd13
  } addmod_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    OP0  = 3'd1,
    OP1  = 3'd2,
    PTR0 = 3'd3,
    PTR1 = 3'd4,
    FIN  = 3'd5
  } seq_state_t;

  function automatic logic [1:0] pc_adv_of(input addmod_t m);
    case (m)
      AM_ABS, AM_ABSX, AM_ABSY, AM_INDY:                       return 2'd2;
      AM_IMM, AM_REL, AM_ZP, AM_ZPX, AM_ZPY, AM_IXID, AM_IDIX: return 2'd1;
      default:                                                 return 2'd0;
    endcase
  endfunction

  function automatic logic mode_err(input addmod_t m);
    return (m == AM_UADDMOD) || (m > AM_IMP);
  endfunction

  // Every mode that consumes operand bytes reads them, except immediate.
  function automatic logic needs_read(input addmod_t m);
    return (pc_adv_of(m) != 2'd0) && (m != AM_IMM);
  endfunction

endpackage

// File: rtl/operand_sequencer_ea_calc.sv
// Final effective-address adder: combines the fetched operand bytes with
// X/Y/PC according to the addressing mode. Purely combinational.
module operand_sequencer_ea_calc
  import operand_sequencer_pkg::*;
(
  input  addmod_t mode,
  input  data_t   lo,
  input  data_t   hi,
  input  data_t   off,
  input  data_t   x,
  input  data_t   y,
  input  addr_t   pc,
  output addr_t   ea
);

  always_comb begin
    ea = '0;
    case (mode)
      AM_IMM:                     ea = pc;
      AM_REL:                     ea = pc + 16'd1 + {{8{off[7]}}, off};
      AM_ZP:                      ea = {8'h00, lo};
      AM_ZPX:                     ea = {8'h00, data_t'(lo + x)};
      AM_ZPY:                     ea = {8'h00, data_t'(lo + y)};
      AM_ABS, AM_IXID, AM_INDY:   ea = {hi, lo};
      AM_ABSX:                    ea = {hi, lo} + {8'h00, x};
      AM_ABSY, AM_IDIX:           ea = {hi, lo} + {8'h00, y};
      default:                    ea = '0;
    endcase
  end

endmodule

// File: rtl/operand_sequencer.sv
// Addressing-mode sequencer: issues operand/pointer reads for the decoded mode
// and returns the effective address and PC advance with a one-cycle done.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  addmod_t    addmod,
  input  addr_t      pc,
  input  data_t      x,
  input  data_t      y,
  output addr_t      mem_addr,
  output logic       mem_rd,
  input  data_t      mem_data,
  output logic       busy,
  output logic       done,
  output addr_t      ea,
  output logic [1:0] pc_adv,
  output logic       err
);

  generate
    if (RD_LAT != 1) begin : g_bad_rd_lat
      $error("operand_sequencer: only RD_LAT = 1 is supported");
    end
  endgenerate

  seq_state_t r_state, w_next;
  addmod_t    r_mode;
  data_t      r_x, r_y, r_b0, r_b1, r_b2;
  addr_t      r_mem_addr, r_ea;
  logic [1:0] r_adv;
  logic       r_err;
  logic       w_rd;
  addr_t      w_addr;
  data_t      w_lo;
  addr_t      w_ea;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Dependent addresses in PTR0 use mem_data directly, saving a cycle per pointer.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_addr = r_mem_addr;
    case (r_state)
      IDLE: if (start) w_next = needs_read(addmod) ? OP0 : FIN;
      OP0: begin
        w_rd   = 1'b1;
        w_addr = pc;
        case (r_mode)
          AM_ABS, AM_ABSX, AM_ABSY, AM_INDY: w_next = OP1;
          AM_IXID, AM_IDIX:                  w_next = PTR0;
          default:                           w_next = FIN;
        endcase
      end
      OP1: begin
        w_rd   = 1'b1;
        w_addr = pc + 16'd1;
        w_next = (r_mode == AM_INDY) ? PTR0 : FIN;
      end
      PTR0: begin
        w_rd   = 1'b1;
        w_next = PTR1;
        case (r_mode)
          AM_IXID: w_addr = {8'h00, data_t'(mem_data + r_x)};
          AM_IDIX: w_addr = {8'h00, mem_data};
          default: w_addr = {mem_data, r_b0};
        endcase
      end
      PTR1: begin
        w_rd   = 1'b1;
        w_next = FIN;
        // INDY keeps the pointer high byte: the NMOS page-wrap behaviour.
        case (r_mode)
          AM_IXID: w_addr = {8'h00, data_t'(r_b0 + r_x + 8'd1)};
          AM_IDIX: w_addr = {8'h00, data_t'(r_b0 + 8'd1)};
          default: w_addr = {r_b1, data_t'(r_b0 + 8'd1)};
        endcase
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= AM_UADDMOD;
      r_x        <= '0;
      r_y        <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_mem_addr <= '0;
      r_ea       <= '0;
      r_adv      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_rd) r_mem_addr <= w_addr;
      if (r_state == IDLE && start) begin
        r_mode <= addmod;
        r_x    <= x;
        r_y    <= y;
      end
      case (r_state)
        OP1:  r_b0 <= mem_data;
        PTR0: if (r_mode == AM_INDY) r_b1 <= mem_data;
              else                   r_b0 <= mem_data;
        PTR1: r_b2 <= mem_data;
        FIN: begin
          r_ea  <= w_ea;
          r_adv <= pc_adv_of(r_mode);
          r_err <= mode_err(r_mode);
        end
        default: ;
      endcase
    end
  end

  // In FIN the last byte is still on mem_data; earlier bytes come from registers.
  always_comb begin
    case (r_mode)
      AM_IXID, AM_IDIX, AM_INDY: w_lo = r_b2;
      AM_ABS, AM_ABSX, AM_ABSY:  w_lo = r_b0;
      default:                   w_lo = mem_data;
    endcase
  end

  operand_sequencer_ea_calc u_ea_calc (
    .mode (r_mode),
    .lo   (w_lo),
    .hi   (mem_data),
    .off  (mem_data),
    .x    (r_x),
    .y    (r_y),
    .pc   (pc),
    .ea   (w_ea)
  );

  assign mem_rd   = w_rd;
  assign mem_addr = w_addr;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FIN);
  assign ea       = done ? w_ea : r_ea;
  assign pc_adv   = done ? pc_adv_of(r_mode) : r_adv;
  assign err      = done ? mode_err(r_mode) : r_err;

endmodule
